// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Multiplexed 7-segment display controller on the CPU I/O bus. It holds one
//   hex nibble per digit and scans NDIGITS digits, one slot of
//   2**SCAN_DIV_W clocks each. Features: per-digit decimal point, per-digit
//   blanking, leading-zero suppression, 16-level PWM brightness and a
//   frame-done strobe.
// Ports
//   clk      system clock
//   reset    asynchronous, active-high reset
//   cs       register write strobe, sampled on posedge clk
//   wr_sel   target register: 0 DATA, 1 DP, 2 BLANK, 3 CTRL
//   i_data   write data, 4*NDIGITS bits (high bits ignored for DP/BLANK/CTRL)
//   o_seg    segments {dp,g,f,e,d,c,b,a}, registered
//   o_sel    digit enables, one-hot when lit, registered
//   o_frame  one-cycle pulse after the scan index wraps to digit 0
module seg_scan_ctrl #(
  parameter int unsigned NDIGITS    = 8,
  parameter int unsigned SCAN_DIV_W = 13,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs,
  input  logic [1:0]             wr_sel,
  input  logic [4*NDIGITS-1:0]   i_data,
  output logic [7:0]             o_seg,
  output logic [NDIGITS-1:0]     o_sel,
  output logic                   o_frame
);

  localparam int unsigned DW = 4 * NDIGITS;
  localparam int unsigned IW = $clog2(NDIGITS);
  localparam logic [IW-1:0]      LAST_IDX = IW'(NDIGITS - 1);
  localparam logic [7:0]         SEG_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NDIGITS-1:0] SEL_OFF  = {NDIGITS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_DP    = 2'd1,
    REG_BLANK = 2'd2,
    REG_CTRL  = 2'd3
  } reg_sel_e;

  logic [DW-1:0]         data_q,  data_d;
  logic [NDIGITS-1:0]    dp_q,    dp_d;
  logic [NDIGITS-1:0]    blank_q, blank_d;
  logic                  en_q,    en_d;
  logic                  lzs_q,   lzs_d;
  logic [3:0]            duty_q,  duty_d;
  logic [SCAN_DIV_W-1:0] presc_q, presc_d;
  logic [IW-1:0]         idx_q,   idx_d;
  logic [7:0]            seg_q,   seg_d;
  logic [NDIGITS-1:0]    sel_q,   sel_d;
  logic                  frame_q, frame_d;

  // Active-low segment pattern {g..a} for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Register file and scan counters.
  always_comb begin
    data_d  = data_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    en_d    = en_q;
    lzs_d   = lzs_q;
    duty_d  = duty_q;
    if (cs) begin
      case (reg_sel_e'(wr_sel))
        REG_DATA:  data_d  = i_data;
        REG_DP:    dp_d    = i_data[NDIGITS-1:0];
        REG_BLANK: blank_d = i_data[NDIGITS-1:0];
        default: begin
          en_d   = i_data[0];
          lzs_d  = i_data[1];
          duty_d = i_data[7:4];
        end
      endcase
    end

    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (&presc_q) begin
      idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      frame_d = (idx_q == LAST_IDX);
    end
  end

  // Output stage: decoded from the pre-edge state, giving one cycle latency.
  always_comb begin
    logic [3:0] nib;
    logic       upper_zero;
    logic       lit;
    logic [7:0] seg_lo;
    logic [NDIGITS-1:0] sel_lo;

    nib        = '0;
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (IW'(i) == idx_q) nib = data_q[4*i +: 4];
      // Leading-zero test covers the current digit and every digit above it.
      if ((IW'(i) >= idx_q) && (data_q[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end

    lit    = en_q && (presc_q[SCAN_DIV_W-1 -: 4] <= duty_q);
    seg_lo = 8'hFF;
    sel_lo = '1;
    if (lit) begin
      sel_lo[idx_q] = 1'b0;
      if (blank_q[idx_q]) begin
        seg_lo = 8'hFF;
      end else if (lzs_q && (idx_q != '0) && upper_zero) begin
        seg_lo = {~dp_q[idx_q], 7'h7F};
      end else begin
        seg_lo = {~dp_q[idx_q], hex_to_seg(nib)};
      end
    end

    seg_d = ACTIVE_LOW ? seg_lo : ~seg_lo;
    sel_d = ACTIVE_LOW ? sel_lo : ~sel_lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      en_q    <= 1'b1;
      lzs_q   <= 1'b0;
      duty_q  <= 4'hF;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
      frame_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      en_q    <= en_d;
      lzs_q   <= lzs_d;
      duty_q  <= duty_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Bench for seg_scan_ctrl with NDIGITS=8, SCAN_DIV_W=5, ACTIVE_LOW=1.
//   A behavioural model predicts the outputs after every clock edge; the
//   prediction is queued at the edge and compared on the following falling
//   edge. Fixed display patterns are also checked against literal values.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic [1:0]  wr_sel = 2'd0;
  logic [31:0] i_data = '0;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;
  logic        o_frame;

  seg_scan_ctrl #(
    .NDIGITS    (8),
    .SCAN_DIV_W (5),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .wr_sel  (wr_sel),
    .i_data  (i_data),
    .o_seg   (o_seg),
    .o_sel   (o_sel),
    .o_frame (o_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] sel;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state
  logic [31:0] m_data;
  logic [7:0]  m_dp, m_blank;
  logic        m_en, m_lzs;
  int unsigned m_duty, m_presc, m_idx;
  int unsigned last_idx, last_presc;
  logic [7:0]  hex_tab [16];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_dp = '0; m_blank = '0;
    m_en = 1'b1; m_lzs = 1'b0; m_duty = 15;
    m_presc = 0; m_idx = 0;
  endtask

  // Predicts outputs produced by one rising edge, then advances model state.
  task automatic model_edge(output exp_t e);
    int unsigned nib;
    logic lit;
    logic [7:0] seg, sel;
    lit = m_en && ((m_presc >> 1) <= m_duty);
    seg = 8'hFF;
    sel = 8'hFF;
    if (lit) begin
      sel = ~(8'h01 << m_idx);
      nib = (m_data >> (4 * m_idx)) & 32'hF;
      if (m_blank[m_idx])
        seg = 8'hFF;
      else if (m_lzs && m_idx != 0 && (m_data >> (4 * m_idx)) == 0)
        seg = m_dp[m_idx] ? 8'h7F : 8'hFF;
      else begin
        seg = hex_tab[nib];
        if (m_dp[m_idx]) seg[7] = 1'b0;
      end
    end
    e.seg = seg;
    e.sel = sel;
    e.frame = (m_presc == 31) && (m_idx == 7);
    last_idx = m_idx;
    last_presc = m_presc;
    if (cs) begin
      case (wr_sel)
        2'd0: m_data = i_data;
        2'd1: m_dp = i_data[7:0];
        2'd2: m_blank = i_data[7:0];
        default: begin
          m_en = i_data[0];
          m_lzs = i_data[1];
          m_duty = i_data[7:4];
        end
      endcase
    end
    if (m_presc == 31) begin
      m_presc = 0;
      m_idx = (m_idx + 1) % 8;
    end else begin
      m_presc++;
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge(e);
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_seg", {24'd0, o_seg}, {24'd0, e.seg});
      chk("sb_sel", {24'd0, o_sel}, {24'd0, e.sel});
      chk("sb_frame", {31'd0, o_frame}, {31'd0, e.frame});
    end
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [31:0] d);
    cs = 1'b1; wr_sel = sel; i_data = d;
    step();
    cs = 1'b0; i_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    chk("rst_seg", {24'd0, o_seg}, 32'hFF);
    chk("rst_sel", {24'd0, o_sel}, 32'hFF);
    chk("rst_frame", {31'd0, o_frame}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_sel", {24'd0, o_sel}, 32'hFF);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] sel_tab [8];
    logic [7:0] t2 [8];
    logic [7:0] t3 [8];
    int frames, lit_cnt;
    bit found;
    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    sel_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    t2 = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    t3 = '{8'hC0, 8'h92, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    @(negedge clk);
    do_reset();

    // 1: idle scan after reset
    frames = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      if (o_frame) begin
        frames++;
        chk("t1_frame_idx", last_idx, 7);
      end
      if (last_presc == 16) begin
        chk("t1_sel", {24'd0, o_sel}, {24'd0, sel_tab[last_idx]});
        chk("t1_seg", {24'd0, o_seg}, 32'hC0);
      end
    end
    chk("t1_frames", frames, 2);

    // 2: hex decode of every digit
    bus_write(2'd0, 32'h1234ABCD);
    for (int i = 0; i < 256; i++) begin
      step();
      if (last_presc == 16) chk("t2_seg", {24'd0, o_seg}, {24'd0, t2[last_idx]});
    end

    // 3: leading-zero suppression, then dp on a suppressed digit
    bus_write(2'd0, 32'h00000050);
    bus_write(2'd3, 32'h000000F3);
    for (int i = 0; i < 256; i++) begin
      step();
      if (last_presc == 16) chk("t3_seg", {24'd0, o_seg}, {24'd0, t3[last_idx]});
    end
    bus_write(2'd1, 32'h00000080);
    for (int i = 0; i < 256; i++) begin
      step();
      if (last_presc == 16 && last_idx == 7) chk("t3_dp7", {24'd0, o_seg}, 32'h7F);
    end

    // 4: blanking keeps the digit selected but dark
    bus_write(2'd2, 32'h00000001);
    bus_write(2'd0, 32'h00000008);
    for (int i = 0; i < 256; i++) begin
      step();
      if (last_presc == 16 && last_idx == 0) begin
        chk("t4_seg", {24'd0, o_seg}, 32'hFF);
        chk("t4_sel", {24'd0, o_sel}, 32'hFE);
      end
    end

    // 5: PWM duty 3, then display disabled
    bus_write(2'd3, 32'h00000031);
    step();
    lit_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (o_sel != 8'hFF) lit_cnt++;
    end
    chk("t5_duty", lit_cnt, 8);
    bus_write(2'd3, 32'h00000000);
    step();
    chk("t5_off_sel", {24'd0, o_sel}, 32'hFF);
    chk("t5_off_seg", {24'd0, o_seg}, 32'hFF);
    for (int i = 0; i < 40; i++) step();

    // 6: asynchronous reset in the middle of slot 3
    bus_write(2'd3, 32'h000000F1);
    bus_write(2'd2, 32'h00000000);
    bus_write(2'd0, 32'h1234ABCD);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_idx == 3 && m_presc == 10) found = 1'b1;
      else step();
    end
    chk("t6_reach_slot3", {31'd0, found}, 32'd1);
    #2;
    do_reset();
    for (int i = 0; i < 20; i++) step();
    chk("t6_sel", {24'd0, o_sel}, 32'hFE);
    chk("t6_seg", {24'd0, o_seg}, 32'hC0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_presc == 16) chk("t6_seg1", {24'd0, o_seg}, 32'hC0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
